// File: rtl/adder_ahead_cla.sv
// Registered two-level carry-lookahead adder built from 4-bit lookahead groups.
// Optional `define ADDER_AHEAD_OVF_EN adds a registered signed-overflow output ovf.

package adder_ahead_cla_pkg;

  // Flattened lookahead carry into position n of a 4-wide slice:
  // OR over j<n of g[j]&p[j+1..n-1], plus p[0..n-1]&ci. No term depends on a prior carry.
  function automatic logic la_carry(input logic [3:0] g, input logic [3:0] p,
                                    input logic ci, input int n);
    logic acc, term;
    acc = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j < n) begin
        term = g[j];
        for (int m = 0; m < 4; m++)
          if (m > j && m < n) term = term & p[m];
        acc = acc | term;
      end
    end
    term = ci;
    for (int m = 0; m < 4; m++)
      if (m < n) term = term & p[m];
    return acc | term;
  endfunction

  function automatic logic la_prop(input logic [3:0] p, input int n);
    logic acc;
    acc = 1'b1;
    for (int m = 0; m < 4; m++)
      if (m < n) acc = acc & p[m];
    return acc;
  endfunction

endpackage

// One 4-bit lookahead group: bit carries, sum and group G/P.
module cla_group4
  import adder_ahead_cla_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       grp_g,
  output logic       grp_p
);
  logic [3:0] g, p, c;

  always_comb begin
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int k = 0; k < 4; k++) c[k] = la_carry(g, p, ci, k);
    s     = p ^ c;
    grp_g = la_carry(g, p, 1'b0, 4);
    grp_p = la_prop(p, 4);
  end
endmodule

// Second-level carry unit over NUM_GRP groups; empty slots are tied to G=P=0
// and the block terms are taken at position NUM_GRP so the ties never matter.
module cla_carry_unit
  import adder_ahead_cla_pkg::*;
#(
  parameter int NUM_GRP = 4
) (
  input  logic [NUM_GRP-1:0] grp_g,
  input  logic [NUM_GRP-1:0] grp_p,
  input  logic               ci,
  output logic [NUM_GRP-1:0] c,
  output logic               c_out,
  output logic               g_out,
  output logic               p_out
);
  logic [3:0] gs, ps;

  always_comb begin
    gs = '0;
    ps = '0;
    gs[NUM_GRP-1:0] = grp_g;
    ps[NUM_GRP-1:0] = grp_p;
    c = '0;
    for (int k = 0; k < NUM_GRP; k++) c[k] = la_carry(gs, ps, ci, k);
    c_out = la_carry(gs, ps, ci, NUM_GRP);
    g_out = la_carry(gs, ps, 1'b0, NUM_GRP);
    p_out = la_prop(ps, NUM_GRP);
  end
endmodule

module adder_ahead_cla #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             g_out,
`ifdef ADDER_AHEAD_OVF_EN
  output logic             ovf,
`endif
  output logic             p_out
);
  localparam int NUM_GRP = (WIDTH >= 4) ? WIDTH / 4 : 1;
  localparam int STAGES  = 1;

  generate
    if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 12 || WIDTH == 16)) begin : g_bad_width
      $error("adder_ahead_cla: WIDTH must be 4, 8, 12 or 16");
    end
  endgenerate

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             g_out;
    logic             p_out;
`ifdef ADDER_AHEAD_OVF_EN
    logic             ovf;
`endif
  } res_t;

  logic [NUM_GRP-1:0][3:0] x_g, y_g, s_g;
  logic [NUM_GRP-1:0]      grp_g, grp_p, grp_ci;
  logic                    cu_c_out, cu_g, cu_p;
  logic [STAGES-1:0]       vld_pipe;
  res_t                    res_d, res_q;

  assign x_g = x;
  assign y_g = y;

  cla_group4 u_grp [NUM_GRP-1:0] (
    .x     (x_g),
    .y     (y_g),
    .ci    (grp_ci),
    .s     (s_g),
    .grp_g (grp_g),
    .grp_p (grp_p)
  );

  cla_carry_unit #(.NUM_GRP(NUM_GRP)) u_cu (
    .grp_g (grp_g),
    .grp_p (grp_p),
    .ci    (c_in),
    .c     (grp_ci),
    .c_out (cu_c_out),
    .g_out (cu_g),
    .p_out (cu_p)
  );

  always_comb begin
    res_d       = '0;
    res_d.sum   = s_g;
    res_d.c_out = cu_c_out;
    res_d.g_out = cu_g;
    res_d.p_out = cu_p;
`ifdef ADDER_AHEAD_OVF_EN
    // Carry into the MSB recovered from its sum bit: s = x ^ y ^ c.
    res_d.ovf   = (s_g[NUM_GRP-1][3] ^ x[WIDTH-1] ^ y[WIDTH-1]) ^ cu_c_out;
`endif
  end

  // Result registers load only on valid cycles, so idle operand garbage never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      res_q    <= '0;
    end else begin
      vld_pipe <= STAGES'({vld_pipe, in_valid});
      if (in_valid) res_q <= res_d;
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign sum       = res_q.sum;
  assign c_out     = res_q.c_out;
  assign g_out     = res_q.g_out;
  assign p_out     = res_q.p_out;
`ifdef ADDER_AHEAD_OVF_EN
  assign ovf       = res_q.ovf;
`endif

endmodule

// File: tb/tb_adder_ahead_cla.sv
// Scoreboard bench for adder_ahead_cla (WIDTH=16): directed vectors, hold and reset checks.
module tb_adder_ahead_cla;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        c_in = 1'b0;
  logic        out_valid;
  logic [15:0] sum;
  logic        c_out, g_out, p_out;
  logic        ovf_w;
`ifdef ADDER_AHEAD_OVF_EN
  logic        ovf;
  assign ovf_w = ovf;
`else
  assign ovf_w = 1'b0;
`endif

  typedef struct {
    logic [15:0] sum;
    logic        c, g, p, o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  adder_ahead_cla #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .c_in      (c_in),
    .out_valid (out_valid),
    .sum       (sum),
    .c_out     (c_out),
    .g_out     (g_out),
`ifdef ADDER_AHEAD_OVF_EN
    .ovf       (ovf),
`endif
    .p_out     (p_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_ovf(input string nm, input logic exp);
`ifdef ADDER_AHEAD_OVF_EN
    chk(nm, {31'd0, ovf_w}, {31'd0, exp});
`endif
  endtask

  // Drives one transaction for a cycle and queues its hand-computed result.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] s, input logic c, input logic g,
                       input logic p, input logic o);
    exp_t e;
    in_valid = 1'b1; x = a; y = b; c_in = ci;
    e.sum = s; e.c = c; e.g = g; e.p = p; e.o = o;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: pops and compares whenever a result is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", {16'd0, sum}, {16'd0, e.sum});
        chk("c_out", {31'd0, c_out}, {31'd0, e.c});
        chk("g_out", {31'd0, g_out}, {31'd0, e.g});
        chk("p_out", {31'd0, p_out}, {31'd0, e.p});
        chk_ovf("ovf", e.o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_sum", {16'd0, sum}, 32'd0);
    chk("idle_cgp", {29'd0, c_out, g_out, p_out}, 32'd0);
    chk_ovf("idle_ovf", 1'b0);

    // Back-to-back directed vectors:  x      y      ci  sum    c  g  p  ovf
    issue(16'h0001, 16'h0001, 1'b1, 16'h0003, 0, 0, 0, 0);
    issue(16'h0001, 16'hFFFF, 1'b1, 16'h0001, 1, 1, 0, 0);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1, 1, 0, 0);
    issue(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1, 0, 1, 0);
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 1, 0, 1);
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 0, 0, 0, 0);
    issue(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 0, 0, 1, 0);
    issue(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1, 0, 1, 0);
    issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0, 0);
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 0, 0, 1);

    // Idle with junk operands: outputs must hold
    in_valid = 1'b0; x = 16'hDEAD; y = 16'hBEEF; c_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_sum", {16'd0, sum}, 32'h8000);
    chk("hold_cgp", {29'd0, c_out, g_out, p_out}, 32'd0);
    chk_ovf("hold_ovf", 1'b1);

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      chk("sb_drain", sb.size(), 32'd0);
    end

    // Asynchronous reset mid-stream discards the in-flight result
    @(posedge clk); #1;
    in_valid = 1'b1; x = 16'h0001; y = 16'h0001; c_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sum", {16'd0, sum}, 32'd0);
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk_ovf("async_rst_ovf", 1'b0);
    @(posedge clk); #1;
    chk("rst_discard_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_discard_sum", {16'd0, sum}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_ahead_cla.md
Name: adder_ahead_cla

Overview:
- Registered two-level carry-lookahead adder, WIDTH bits, built from 4-bit lookahead groups.
- Each group produces its own group generate/propagate. A second-level lookahead carry unit derives the inter-group carries and the block-level G/P.
- Used as the arithmetic slice in datapaths and cascadable through g_out/p_out into a higher-level carry unit.
- One-cycle registered result with valid qualifier.

Parameters:
- WIDTH, 16, operand width.
  - Legal values: 4, 8, 12, 16.
  - Other values: elaboration error via a generate-time check.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- out_valid  output  1  registered result valid
- sum  output  WIDTH  registered x+y+c_in, modulo 2^WIDTH
- c_out  output  1  registered carry out of MSB
- g_out  output  1  registered block generate
- p_out  output  1  registered block propagate

Behaviour:
- Reset and clocking:
  - One clock (clk); reset is asynchronous, active-low (rst_n).
  - While rst_n=0: out_valid, sum, c_out, g_out, p_out all 0.
  - Reset is released synchronously to clk.
- Bit level:
  - g_i = x_i & y_i.
  - p_i = x_i ^ y_i.
  - sum_i = p_i ^ c_i, with c_0 = c_in.
- Group level, k = 0..WIDTH/4-1, bits 4k..4k+3:
  - Internal carries are flattened lookahead equations; no ripple. Example: c1 = g0 | p0·c0, c2 = g1 | p1·g0 | p1·p0·c0, and so on.
  - Group G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Group P = p3p2p1p0.
- Carry unit:
  - Takes up to 4 group G/P pairs plus c_in and produces carry into group k+1 as C(k+1) = G(k) | P(k)·C(k), flattened.
  - Block g_out/p_out use the same G/P formulas over the groups.
  - Unused group slots (WIDTH<16) tie to G=0, P=0 and do not affect outputs.
  - c_out is the carry out of the last group.
  - g_out and p_out are independent of c_in.
- Timing:
  - Latency 1 cycle. On a clk edge with in_valid=1, all result registers load and out_valid<=1.
  - On a clk edge with in_valid=0: out_valid<=0; sum, c_out, g_out, p_out hold their previous values.
  - Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- Boundaries:
  - All-ones + all-ones + 1: sum all-ones, c_out=1.
  - Wrap-around is modulo 2^WIDTH.
  - X/Z on operands while in_valid=0 must not propagate into held outputs.
- Reset asserted mid-stream clears outputs immediately; the in-flight result is discarded.

Optional Feature:
- Macro ADDER_AHEAD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0, loads with the other result registers).
  - ovf = carry into MSB XOR c_out, i.e. two's-complement signed overflow.
- Undefined: ovf port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16; reset asserted, then released; idle cycles -> all outputs 0, including ovf.
- x=0x0001, y=0x0001, c_in=1, in_valid=1 -> next cycle out_valid=1, sum=0x0003, c_out=0, g_out=0, p_out=0.
- x=0x0001, y=0xFFFF, c_in=1 -> sum=0x0001, c_out=1, g_out=1, p_out=0; with ADDER_AHEAD_OVF_EN, ovf=0.
- x=0xFFFF, y=0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1, g_out=1, p_out=0.
- x=0x0000, y=0xFFFF, c_in=1 -> sum=0x0000, c_out=1, g_out=0, p_out=1.
- x=0x7FFF, y=0x0001, c_in=0 (ovf=1 when enabled), then in_valid=0 for 2 cycles -> out_valid=0, sum holds 0x8000. Then pulse rst_n low asynchronously -> outputs 0 without a clock edge.
